// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BE_W        = 2;
    localparam int unsigned NUM_PORTS   = 3;
    localparam int unsigned PORT_W      = 2;

    localparam logic [PORT_W-1:0] PORT_VIDEO = 2'd0;
    localparam logic [PORT_W-1:0] PORT_BUS   = 2'd1;
    localparam logic [PORT_W-1:0] PORT_PROC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2
    } state_t;

    // Latched grant; address, data and byte enables live directly on the pin registers.
    typedef struct packed {
        logic [NUM_PORTS-1:0] portOh;
        logic                 rdNwr;
    } grant_t;

    // Round-robin successor between the two non-real-time ports.
    function automatic logic [PORT_W-1:0] otherRr(input logic [PORT_W-1:0] port);
        return (port == PORT_BUS) ? PORT_PROC : PORT_BUS;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selector: video first unless starving, else round-robin between bus and proc.
module sram_arb_pick
    import sram_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [PORT_W-1:0]    rrPtr,
    input  logic                 starve,
    output logic [NUM_PORTS-1:0] winnerOh_c,
    output logic [PORT_W-1:0]    winnerIdx_c
);

    logic busValid;
    logic procValid;
    logic rrAny;
    logic takeVideo;
    logic [PORT_W-1:0] rrIdx;

    always_comb begin
        busValid  = valid[PORT_BUS];
        procValid = valid[PORT_PROC];
        rrAny     = busValid | procValid;
        rrIdx     = PORT_BUS;
        if (procValid && ((rrPtr == PORT_PROC) || !busValid)) begin
            rrIdx = PORT_PROC;
        end

        // Starvation only overrides video when someone else is actually waiting.
        takeVideo = valid[PORT_VIDEO] && !(starve && rrAny);

        winnerIdx_c = PORT_VIDEO;
        if (!takeVideo && rrAny) begin
            winnerIdx_c = rrIdx;
        end

        winnerOh_c = '0;
        if (takeVideo || rrAny) begin
            case (winnerIdx_c)
                PORT_BUS:  winnerOh_c = 3'b010;
                PORT_PROC: winnerOh_c = 3'b100;
                default:   winnerOh_c = 3'b001;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter owning the asynchronous 256Kx16 SRAM pins; two-cycle SETUP/STROBE access.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = SRAM_ADDR_W
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [NUM_PORTS-1:0]          iReq_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   iReq_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   iReq_data,
    input  logic [NUM_PORTS-1:0]          iReq_rd_Nwr,
    input  logic [NUM_PORTS*BE_W-1:0]     iReq_byte_en,
    output logic [NUM_PORTS-1:0]          oArbited,
    output logic [DATA_W-1:0]             oRdata,
    input  logic [DATA_W-1:0]             iSRAM_DQ,
    output logic [DATA_W-1:0]             oSRAM_DQ,
    output logic                          oSRAM_DQ_oe,
    output logic [ADDR_W-1:0]             oSRAM_ADDR,
    output logic                          oSRAM_CE_N,
    output logic                          oSRAM_OE_N,
    output logic                          oSRAM_WE_N,
    output logic                          oSRAM_UB_N,
    output logic                          oSRAM_LB_N
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t              state;
    grant_t              grant;
    logic [PORT_W-1:0]   rrPtr;
    logic [CNT_W-1:0]    starveCnt;
    logic                rdStrobe;

    logic                anyValid;
    logic                pending;
    logic                starveFlag;
    logic [NUM_PORTS-1:0] winnerOh;
    logic [PORT_W-1:0]   winnerIdx;

    logic [ADDR_W-1:0]   selAddr;
    logic [DATA_W-1:0]   selData;
    logic                selRd;
    logic [BE_W-1:0]     selBe;

    assign anyValid   = |iReq_valid;
    assign pending    = iReq_valid[PORT_BUS] | iReq_valid[PORT_PROC];
    assign starveFlag = (starveCnt == CNT_MAX);

    sram_arb_pick uPick (
        .valid       (iReq_valid),
        .rrPtr       (rrPtr),
        .starve      (starveFlag),
        .winnerOh_c  (winnerOh),
        .winnerIdx_c (winnerIdx)
    );

    // Request field mux for the current winner.
    always_comb begin
        selAddr = iReq_addr[0 +: ADDR_W];
        selData = iReq_data[0 +: DATA_W];
        selRd   = iReq_rd_Nwr[0];
        selBe   = iReq_byte_en[0 +: BE_W];
        case (winnerIdx)
            PORT_BUS: begin
                selAddr = iReq_addr[ADDR_W +: ADDR_W];
                selData = iReq_data[DATA_W +: DATA_W];
                selRd   = iReq_rd_Nwr[1];
                selBe   = iReq_byte_en[BE_W +: BE_W];
            end
            PORT_PROC: begin
                selAddr = iReq_addr[2*ADDR_W +: ADDR_W];
                selData = iReq_data[2*DATA_W +: DATA_W];
                selRd   = iReq_rd_Nwr[2];
                selBe   = iReq_byte_en[2*BE_W +: BE_W];
            end
            default: ;
        endcase
    end

    // Read data passes straight through during the read strobe only.
    assign oRdata = rdStrobe ? iSRAM_DQ : '0;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= ST_IDLE;
            grant       <= '0;
            rrPtr       <= PORT_BUS;
            starveCnt   <= '0;
            rdStrobe    <= 1'b0;
            oArbited    <= '0;
            oSRAM_ADDR  <= '0;
            oSRAM_DQ    <= '0;
            oSRAM_DQ_oe <= 1'b0;
            oSRAM_CE_N  <= 1'b1;
            oSRAM_OE_N  <= 1'b1;
            oSRAM_WE_N  <= 1'b1;
            oSRAM_UB_N  <= 1'b1;
            oSRAM_LB_N  <= 1'b1;
        end else begin
            oArbited <= '0;
            rdStrobe <= 1'b0;
            case (state)
                ST_IDLE, ST_STROBE: begin
                    if (anyValid) begin
                        state        <= ST_SETUP;
                        grant.portOh <= winnerOh;
                        grant.rdNwr  <= selRd;
                        oSRAM_ADDR   <= selAddr;
                        oSRAM_DQ     <= selData;
                        oSRAM_DQ_oe  <= ~selRd;
                        oSRAM_CE_N   <= 1'b0;
                        oSRAM_OE_N   <= ~selRd;
                        oSRAM_WE_N   <= 1'b1;
                        oSRAM_UB_N   <= ~selBe[1];
                        oSRAM_LB_N   <= ~selBe[0];
                        if (winnerIdx == PORT_VIDEO) begin
                            if (!pending) begin
                                starveCnt <= '0;
                            end else if (!starveFlag) begin
                                starveCnt <= starveCnt + CNT_W'(1);
                            end
                        end else begin
                            rrPtr     <= otherRr(winnerIdx);
                            starveCnt <= '0;
                        end
                    end else begin
                        state       <= ST_IDLE;
                        oSRAM_DQ_oe <= 1'b0;
                        oSRAM_CE_N  <= 1'b1;
                        oSRAM_OE_N  <= 1'b1;
                        oSRAM_WE_N  <= 1'b1;
                        oSRAM_UB_N  <= 1'b1;
                        oSRAM_LB_N  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state      <= ST_STROBE;
                    oSRAM_WE_N <= grant.rdNwr;
                    oArbited   <= grant.portOh;
                    rdStrobe   <= grant.rdNwr;
                end
                default: begin
                    state       <= ST_IDLE;
                    oSRAM_DQ_oe <= 1'b0;
                    oSRAM_CE_N  <= 1'b1;
                    oSRAM_OE_N  <= 1'b1;
                    oSRAM_WE_N  <= 1'b1;
                    oSRAM_UB_N  <= 1'b1;
                    oSRAM_LB_N  <= 1'b1;
                end
            endcase
        end
    end

endmodule
